// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - UART byte stream to instruction RAM loader; optional INST_LOADER_CHECKSUM_EN adds a trailing checksum check
module inst_loader #(
    parameter int w         = 32,
    parameter int DEPTH     = 2048,
    parameter int BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         is_write,
    output logic [w-1:0] im_addr,
    output logic [w-1:0] im_inst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_hold,
    output logic [w-1:0] words_loaded
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
    localparam logic [2:0] S_CHK   = 3'd6;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_FINISH = S_CHK;
`else
    localparam logic [2:0] S_FINISH = S_DONE;
`endif

    logic [2:0]   state;
    logic [1:0]   byte_cnt;
    logic [23:0]  shift;
    logic [w-1:0] len;
    logic         accept;
    logic [31:0]  word_next;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [w-1:0] sum;
`endif

    assign accept    = rx_valid && rx_ready;
    // Little-endian assembly: newest byte enters at the top, first byte ends in [7:0].
    assign word_next = {rx_data, shift};

    assign rx_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
    assign busy     = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE) || (state == S_CHK);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign cpu_hold = (state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            byte_cnt     <= 2'd0;
            shift        <= '0;
            len          <= '0;
            is_write     <= 1'b0;
            im_addr      <= '0;
            im_inst      <= '0;
            words_loaded <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            is_write <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN;
                        words_loaded <= '0;
                        byte_cnt     <= 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
                        sum          <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        shift    <= word_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            len <= word_next;
                            if (word_next == 32'd0)
                                state <= S_FINISH;
                            else if (word_next > 32'(DEPTH))
                                state <= S_ERR;
                            else
                                state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shift    <= word_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= S_WRITE;
                            is_write <= 1'b1;
                            im_addr  <= 32'(BASE_ADDR) + {words_loaded[29:0], 2'b00};
                            im_inst  <= word_next;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + 32'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum          <= sum + im_inst;
`endif
                    state        <= (words_loaded + 32'd1 == len) ? S_FINISH : S_DATA;
                end
`ifdef INST_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        shift    <= word_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= (word_next == sum) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - randomized self-checking bench for inst_loader against a word-list reference model
module tb_inst_loader;

    localparam int DEPTH = 2048;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, is_write, busy, done, err, cpu_hold;
    logic [31:0] im_addr, im_inst, words_loaded;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_words[$];
    logic [63:0] wq[$];

    inst_loader #(.w(32), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .is_write(is_write), .im_addr(im_addr), .im_inst(im_inst),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Capture every write strobe; the loader must never accept bytes while writing.
    always @(negedge clk) begin
        if (rst_n && is_write) begin
            wq.push_back({im_addr, im_inst});
            vectors++;
            if (rx_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rx_ready_during_write: got %b want 0", rx_ready);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_timeout: rx_ready=%b want 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] v, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], $urandom_range(maxgap, 0));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done === 1'b1 || err === 1'b1) && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic load_image(input int maxgap);
        logic [31:0] s;
        s = 32'h0;
        wq.delete();
        do_start();
        send_word(32'(exp_words.size()), maxgap);
        foreach (exp_words[i]) begin
            send_word(exp_words[i], maxgap);
            s = s + exp_words[i];
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send_word(s, maxgap);
`endif
        wait_end();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({rx_ready, is_write, busy, done, err, cpu_hold} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000001", {rx_ready, is_write, busy, done, err, cpu_hold});
        end
        vectors++;
        if ({im_addr, im_inst, words_loaded} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got %h %h %h want 0", im_addr, im_inst, words_loaded);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_two_words();
        exp_words = '{32'h00000013, 32'h00100093};
        load_image(0);
        vectors++;
        if (wq.size() != 2) begin
            miscompares++;
            $display("FAIL two_words_count: got %0d want 2", wq.size());
        end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            vectors++;
            if (wq[i] !== {BASE + 32'(4*i), exp_words[i]}) begin
                miscompares++;
                $display("FAIL two_words_write%0d: got %h want %h", i, wq[i], {BASE + 32'(4*i), exp_words[i]});
            end
        end
        vectors++;
        if ({done, cpu_hold, busy, words_loaded} !== {3'b100, 32'd2}) begin
            miscompares++;
            $display("FAIL two_words_status: got done=%b hold=%b busy=%b wl=%0d want 1 0 0 2", done, cpu_hold, busy, words_loaded);
        end
    endtask

    task automatic test_zero_len();
        int t;
        wq.delete();
        do_start();
        vectors++;
        if ({busy, cpu_hold, done, words_loaded} !== {3'b110, 32'd0}) begin
            miscompares++;
            $display("FAIL zero_len_started: got busy=%b hold=%b done=%b wl=%0d want 1 1 0 0", busy, cpu_hold, done, words_loaded);
        end
        send_word(32'h0, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_word(32'h0, 0);
`endif
        t = 0;
        while (done !== 1'b1 && t < 2) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len_done: got done=%b hold=%b want 1 0", done, cpu_hold);
        end
        vectors++;
        if (wq.size() != 0) begin
            miscompares++;
            $display("FAIL zero_len_writes: got %0d want 0", wq.size());
        end
    endtask

    task automatic test_too_long();
        wq.delete();
        do_start();
        send_word(32'(DEPTH + 1), 1);
        wait_end();
        vectors++;
        if ({err, done, cpu_hold, busy, rx_ready} !== 5'b10100) begin
            miscompares++;
            $display("FAIL too_long_status: got err=%b done=%b hold=%b busy=%b rdy=%b want 1 0 1 0 0", err, done, cpu_hold, busy, rx_ready);
        end
        vectors++;
        if (wq.size() != 0) begin
            miscompares++;
            $display("FAIL too_long_writes: got %0d want 0", wq.size());
        end
    endtask

    task automatic test_gaps_and_stall();
        logic [31:0] v;
        v = 32'hDEADBEEF;
        wq.delete();
        do_start();
        send_word(32'd1, 3);
        do_start();
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], $urandom_range(3, 0));
        vectors++;
        if (is_write !== 1'b1 || im_addr !== BASE || im_inst !== v) begin
            miscompares++;
            $display("FAIL gap_write_latency: got we=%b addr=%h inst=%h want 1 %h %h", is_write, im_addr, im_inst, BASE, v);
        end
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        vectors++;
        if (rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_ready_in_write: got %b want 0", rx_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if ({done, rx_ready, words_loaded} !== {2'b10, 32'd1} || wq.size() != 1) begin
            miscompares++;
            $display("FAIL gap_final: got done=%b rdy=%b wl=%0d writes=%0d want 1 0 1 1", done, rx_ready, words_loaded, wq.size());
        end
    endtask

    task automatic test_reset_mid_load();
        wq.delete();
        do_start();
        send_word(32'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rx_ready, is_write, busy, done, err, cpu_hold, im_addr, im_inst, words_loaded} !== {6'b000001, 96'h0}) begin
            miscompares++;
            $display("FAIL mid_reset: got flags=%b addr=%h inst=%h wl=%0d want 000001 0 0 0",
                     {rx_ready, is_write, busy, done, err, cpu_hold}, im_addr, im_inst, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_words = '{32'h11223344, 32'hCAFEF00D};
        load_image(2);
        vectors++;
        if (wq.size() != 2 || wq[0] !== {BASE, exp_words[0]} || wq[1] !== {BASE + 32'd4, exp_words[1]} || done !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_reload: got n=%0d done=%b want 2 writes from %h, done=1", wq.size(), done, BASE);
        end
    endtask

    task automatic test_random_loads();
        int n;
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(6, 1);
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back($urandom);
            load_image($urandom_range(3, 0));
            vectors++;
            if (wq.size() != n) begin
                miscompares++;
                $display("FAIL rand%0d_count: got %0d want %0d", it, wq.size(), n);
            end
            for (int i = 0; i < n && i < wq.size(); i++) begin
                vectors++;
                if (wq[i] !== {BASE + 32'(4*i), exp_words[i]}) begin
                    miscompares++;
                    $display("FAIL rand%0d_write%0d: got %h want %h", it, i, wq[i], {BASE + 32'(4*i), exp_words[i]});
                end
            end
            vectors++;
            if ({done, err, cpu_hold, words_loaded} !== {3'b100, 32'(n)}) begin
                miscompares++;
                $display("FAIL rand%0d_status: got done=%b err=%b hold=%b wl=%0d want 1 0 0 %0d", it, done, err, cpu_hold, words_loaded, n);
            end
        end
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        exp_words = '{32'h00000001, 32'hFFFFFFFF};
        load_image(0);
        vectors++;
        if (done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL csum_good: got done=%b err=%b want 1 0", done, err);
        end
        do_start();
        send_word(32'd2, 0);
        send_word(32'h00000001, 0);
        send_word(32'hFFFFFFFF, 0);
        send_word(32'h00000001, 0);
        wait_end();
        vectors++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL csum_bad: got err=%b done=%b hold=%b want 1 0 1", err, done, cpu_hold);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_too_long();
        test_gaps_and_stall();
        test_reset_mid_load();
        test_random_loads();
`ifdef INST_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
